turn_signal_stalk_ctrl: RTL and testbench

Upstream driver for the ThunderBird tail-light sequencer. It produces the `TurnLeft`/`TurnRight` request levels that the sequencer consumes. Raw stalk and hazard switches are synchronised and debounced, then resolved by a Moore FSM into left, right or hazard requests. Self-cancel comes from a steering-return pulse or a timeout.

---
 rtl/turn_signal_pkg.sv | 29 ++
 rtl/turn_signal_stalk_ctrl_input_debouncer.sv | 68 ++++++
 rtl/turn_signal_stalk_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_turn_signal_stalk_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
// -----------------------------------------------------------------------------
// turn_signal_pkg
//
// Shared definitions for the turn-signal stalk controller.
//   state_t              : request state of the stalk FSM (2-bit encoding)
//   DEF_SYNC_STAGES      : default synchroniser depth per raw input
//   DEF_DEBOUNCE_CYCLES  : default stable-cycle count before a level flips
//   DEF_TIMEOUT_CYCLES   : default lifetime of a LEFT/RIGHT request
// -----------------------------------------------------------------------------
package turn_signal_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LEFT   = 2'd1,
      ST_RIGHT  = 2'd2,
      ST_HAZARD = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_TIMEOUT_CYCLES  = 64;

   // True for the two single-direction request states, which are the only
   // states subject to self-cancel and the timeout.
   function automatic logic is_direction(input state_t s);
      return (s == ST_LEFT) || (s == ST_RIGHT);
   endfunction

endpackage

// File: rtl/turn_signal_stalk_ctrl_input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Brings one raw asynchronous contact into the clock domain and debounces it.
// The raw level passes through SYNC_STAGES flops; the debounced level then
// follows the synchroniser output only after it has disagreed with the
// debounced level for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle
// restarts the count.
//
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset (clears sync chain, level, count)
//   raw_i    : raw asynchronous input
//   level_o  : debounced level (registered)
// -----------------------------------------------------------------------------
module input_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o
);

   // A count of DEBOUNCE_CYCLES-1 is the largest value ever stored; keep at
   // least one bit so DEBOUNCE_CYCLES == 1 still elaborates.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   level_q;
   logic                   level_d;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync_out != level_q) begin
         // The flip happens on the DEBOUNCE_CYCLES-th disagreeing cycle,
         // i.e. when that many cycles have been seen including this one.
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/turn_signal_stalk_ctrl.sv
// -----------------------------------------------------------------------------
// turn_signal_stalk_ctrl
//
// Produces the TurnLeft/TurnRight request levels for the tail-light
// sequencer. Stalk and hazard switches are synchronised and debounced, the
// hazard button is reduced to a rising-edge event, and a Moore FSM resolves
// left, right and hazard requests. LEFT/RIGHT self-cancel on a steering-return
// pulse or after TIMEOUT_CYCLES cycles, after which a lockout holds further
// direction requests off until both stalk contacts have been released.
//
// Ports:
//   clk          : clock, rising edge
//   RESET        : synchronous active-high reset
//   StalkLeft    : raw bouncy stalk-left contact
//   StalkRight   : raw bouncy stalk-right contact
//   HazardButton : raw momentary hazard push-button
//   CancelPulse  : synchronous single-cycle steering-return pulse
//   TurnLeft     : left request (LEFT or HAZARD)
//   TurnRight    : right request (RIGHT or HAZARD)
//   Locked       : self-cancel lockout active
//   StalkFault   : both debounced stalk levels high
//
// Handshake: there is none; every input is a level or single-cycle pulse
// sampled on each rising edge, and every output is a level valid for the
// whole cycle following the edge that produced it.
// -----------------------------------------------------------------------------
module turn_signal_stalk_ctrl
   import turn_signal_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic RESET,
   input  logic StalkLeft,
   input  logic StalkRight,
   input  logic HazardButton,
   input  logic CancelPulse,
   output logic TurnLeft,
   output logic TurnRight,
   output logic Locked,
   output logic StalkFault
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------------------
   logic deb_l;
   logic deb_r;
   logic deb_hz;

   input_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_left (
      .clk_i   (clk),
      .rst_i   (RESET),
      .raw_i   (StalkLeft),
      .level_o (deb_l)
   );

   input_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_right (
      .clk_i   (clk),
      .rst_i   (RESET),
      .raw_i   (StalkRight),
      .level_o (deb_r)
   );

   input_debouncer #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_deb_hazard (
      .clk_i   (clk),
      .rst_i   (RESET),
      .raw_i   (HazardButton),
      .level_o (deb_hz)
   );

   // ---------------------------------------------------------------------------
   // Hazard edge detect and stalk decode
   // ---------------------------------------------------------------------------
   logic hz_dly_q;
   logic hz_rise;
   logic stalk_l;
   logic stalk_r;

   // The delay flop resets to 0 together with the debounced level, so a
   // button held through reset still needs a fresh debounced 0->1 to toggle.
   assign hz_rise = deb_hz & ~hz_dly_q;

   // A stalk reading both directions at once is a contact fault and
   // requests neither direction.
   assign stalk_l    = deb_l & ~deb_r;
   assign stalk_r    = deb_r & ~deb_l;
   assign StalkFault = deb_l & deb_r;

   // ---------------------------------------------------------------------------
   // Request FSM, timeout counter and lockout
   // ---------------------------------------------------------------------------
   state_t           state_q;
   state_t           state_d;
   logic [TMR_W-1:0] tmr_q;
   logic [TMR_W-1:0] tmr_d;
   logic             locked_q;
   logic             locked_d;
   logic             set_lock;
   logic             timeout;

   // The counter is held at zero outside LEFT/RIGHT, so this compare only
   // ever matches while a direction request is active.
   assign timeout = (tmr_q == TMR_LAST);

   always_comb begin
      state_d  = state_q;
      set_lock = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (hz_rise) begin
               state_d = ST_HAZARD;
            end else if (stalk_l && !locked_q) begin
               state_d = ST_LEFT;
            end else if (stalk_r && !locked_q) begin
               state_d = ST_RIGHT;
            end
         end
         ST_LEFT: begin
            if (hz_rise) begin
               state_d = ST_HAZARD;
            end else if (CancelPulse || timeout) begin
               state_d  = ST_IDLE;
               set_lock = 1'b1;
            end else if (stalk_r) begin
               state_d = ST_RIGHT;
            end else if (!deb_l) begin
               state_d = ST_IDLE;
            end
         end
         ST_RIGHT: begin
            if (hz_rise) begin
               state_d = ST_HAZARD;
            end else if (CancelPulse || timeout) begin
               state_d  = ST_IDLE;
               set_lock = 1'b1;
            end else if (stalk_l) begin
               state_d = ST_LEFT;
            end else if (!deb_r) begin
               state_d = ST_IDLE;
            end
         end
         ST_HAZARD: begin
            // Stalks, cancel and timeout have no effect while hazards run;
            // stalk levels are looked at again from IDLE on the next cycle.
            if (hz_rise) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      tmr_d = '0;
      if ((state_d == state_q) && is_direction(state_q)) begin
         tmr_d = tmr_q + 1'b1;
      end
   end

   // A self-cancel sets the lock even if the stalks happen to read released
   // on the same cycle; the release clears it again one cycle later.
   always_comb begin
      locked_d = locked_q;
      if (set_lock) begin
         locked_d = 1'b1;
      end else if (!deb_l && !deb_r) begin
         locked_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         tmr_q    <= '0;
         locked_q <= 1'b0;
         hz_dly_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         locked_q <= locked_d;
         hz_dly_q <= deb_hz;
      end
   end

   // ---------------------------------------------------------------------------
   // Moore outputs, decoded from the state register only
   // ---------------------------------------------------------------------------
   assign TurnLeft  = (state_q == ST_LEFT)  || (state_q == ST_HAZARD);
   assign TurnRight = (state_q == ST_RIGHT) || (state_q == ST_HAZARD);
   assign Locked    = locked_q;

endmodule

// File: tb/tb_turn_signal_stalk_ctrl.sv
// -----------------------------------------------------------------------------
// tb_turn_signal_stalk_ctrl
//
// Directed bench for turn_signal_stalk_ctrl with default parameters.
// Inputs change 1 time unit after a rising edge, so the next edge is the
// first to sample them; outputs are checked 1 time unit after an edge.
// Observed/expected vectors are {TurnLeft, TurnRight, Locked, StalkFault}.
// -----------------------------------------------------------------------------
module tb_turn_signal_stalk_ctrl;
  import turn_signal_pkg::*;

  logic clk;
  logic RESET;
  logic StalkLeft;
  logic StalkRight;
  logic HazardButton;
  logic CancelPulse;
  logic TurnLeft;
  logic TurnRight;
  logic Locked;
  logic StalkFault;

  int total;
  int bad;

  turn_signal_stalk_ctrl dut (
    .clk          (clk),
    .RESET        (RESET),
    .StalkLeft    (StalkLeft),
    .StalkRight   (StalkRight),
    .HazardButton (HazardButton),
    .CancelPulse  (CancelPulse),
    .TurnLeft     (TurnLeft),
    .TurnRight    (TurnRight),
    .Locked       (Locked),
    .StalkFault   (StalkFault)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {TurnLeft, TurnRight, Locked, StalkFault};
  endfunction

  initial begin
    total        = 0;
    bad          = 0;
    RESET        = 1'b1;
    StalkLeft    = 1'b1;
    StalkRight   = 1'b0;
    HazardButton = 1'b1;
    CancelPulse  = 1'b0;

    // 1. Reset with raw inputs toggling
    tick(1);
    check("reset_edge1_outs", outs(), 4'b0000);
    check("reset_edge1_state", {2'b00, dut.state_q}, {2'b00, ST_IDLE});
    StalkLeft    = 1'b0;
    StalkRight   = 1'b1;
    HazardButton = 1'b0;
    tick(1);
    check("reset_edge2_outs", outs(), 4'b0000);
    RESET      = 1'b0;
    StalkRight = 1'b0;
    tick(8);
    check("post_reset_idle", outs(), 4'b0000);

    // 2. Stalk hold: 7-edge latency on press and release
    StalkLeft = 1'b1;
    tick(6);
    check("left_press_edge6", outs(), 4'b0000);
    tick(1);
    check("left_press_edge7", outs(), 4'b1000);
    StalkLeft = 1'b0;
    tick(6);
    check("left_release_edge6", outs(), 4'b1000);
    tick(1);
    check("left_release_edge7", outs(), 4'b0000);
    tick(3);

    // 3. Bounce rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
    StalkRight = 1'b1;
    tick(3);
    StalkRight = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bounce3_no_right", outs(), 4'b0000);
    end
    StalkRight = 1'b1;
    tick(4);
    StalkRight = 1'b0;
    tick(2);
    check("bounce4_edge6", outs(), 4'b0000);
    tick(1);
    check("bounce4_edge7", outs(), 4'b0100);
    tick(3);
    check("bounce4_edge10", outs(), 4'b0100);
    tick(1);
    check("bounce4_edge11", outs(), 4'b0000);
    tick(3);

    // 4. Hazard on, stalk ignored, hazard off, stalk re-evaluated
    HazardButton = 1'b1;
    tick(6);
    HazardButton = 1'b0;
    check("hazard_on_edge6", outs(), 4'b0000);
    tick(1);
    check("hazard_on_edge7", outs(), 4'b1100);
    StalkRight = 1'b1;
    tick(10);
    check("hazard_ignores_stalk", outs(), 4'b1100);
    HazardButton = 1'b1;
    tick(6);
    HazardButton = 1'b0;
    check("hazard_off_edge6", outs(), 4'b1100);
    tick(1);
    check("hazard_off_edge7", outs(), 4'b0000);
    tick(1);
    check("hazard_exit_right", outs(), 4'b0100);
    StalkRight = 1'b0;
    tick(6);
    check("right_release_edge6", outs(), 4'b0100);
    tick(1);
    check("right_release_edge7", outs(), 4'b0000);
    tick(3);

    // 5. Timeout after exactly 64 cycles, lockout, release and re-press
    StalkLeft = 1'b1;
    tick(7);
    check("timeout_enter_left", outs(), 4'b1000);
    tick(63);
    check("timeout_cycle64_high", outs(), 4'b1000);
    tick(1);
    check("timeout_fired_locked", outs(), 4'b0010);
    tick(10);
    check("locked_while_held", outs(), 4'b0010);
    StalkLeft = 1'b0;
    tick(6);
    check("lock_release_edge6", outs(), 4'b0010);
    tick(1);
    check("lock_release_edge7", outs(), 4'b0000);
    StalkLeft = 1'b1;
    tick(7);
    check("repress_left", outs(), 4'b1000);
    StalkLeft = 1'b0;
    tick(7);
    check("repress_release", outs(), 4'b0000);
    tick(3);

    // 6. Cancel in RIGHT, then both stalks high
    StalkRight = 1'b1;
    tick(7);
    check("cancel_enter_right", outs(), 4'b0100);
    CancelPulse = 1'b1;
    tick(1);
    CancelPulse = 1'b0;
    check("cancel_right_drop", outs(), 4'b0010);
    tick(3);
    check("cancel_stays_locked", outs(), 4'b0010);
    StalkLeft = 1'b1;
    tick(6);
    check("fault_both_high", outs(), 4'b0011);
    tick(3);
    check("fault_no_request", outs(), 4'b0011);
    StalkLeft  = 1'b0;
    StalkRight = 1'b0;
    tick(6);
    check("fault_cleared", outs(), 4'b0010);
    tick(1);
    check("fault_lock_cleared", outs(), 4'b0000);
    tick(3);

    // 7. hz_rise coinciding with CancelPulse in LEFT -> HAZARD, no lock
    StalkLeft = 1'b1;
    tick(7);
    check("hzcancel_enter_left", outs(), 4'b1000);
    HazardButton = 1'b1;
    tick(6);
    HazardButton = 1'b0;
    CancelPulse  = 1'b1;
    tick(1);
    CancelPulse = 1'b0;
    check("hzcancel_hazard_unlocked", outs(), 4'b1100);
    StalkLeft = 1'b0;
    tick(10);
    check("hzcancel_hazard_hold", outs(), 4'b1100);
    HazardButton = 1'b1;
    tick(6);
    HazardButton = 1'b0;
    tick(1);
    check("hzcancel_hazard_off", outs(), 4'b0000);
    tick(3);

    // 8. Reset mid-request drops the request at that edge
    StalkLeft = 1'b1;
    tick(7);
    check("midreset_enter_left", outs(), 4'b1000);
    RESET = 1'b1;
    tick(1);
    check("midreset_drop", outs(), 4'b0000);
    RESET = 1'b0;
    tick(6);
    check("midreset_relatch_edge6", outs(), 4'b0000);
    tick(1);
    check("midreset_relatch_edge7", outs(), 4'b1000);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
